rsa_avalon_wrapper: RTL

RSA_AVALON_WRAPPER -- requirements
Module: rsa_avalon_wrapper

---
 rtl/rsa_avalon_wrapper.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/rsa_avalon_wrapper.sv
// ============================================================================
// rsa_avalon_wrapper
// Avalon-MM UART master that feeds an RSA modular-exponentiation core.
// Option: RSA_WRAPPER_FULL_BLOCK_EN sends 32 result bytes instead of 31.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rsa_avalon_wrapper #(
  parameter int unsigned RX_BASE     = 0,
  parameter int unsigned TX_BASE     = 4,
  parameter int unsigned STATUS_BASE = 8,
  parameter int unsigned RX_OK_BIT   = 7,
  parameter int unsigned TX_OK_BIT   = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  output logic [4:0]   avm_address,
  output logic         avm_read,
  input  logic [31:0]  avm_readdata,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  input  logic         avm_waitrequest,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_e,
  output logic [255:0] o_core_n,
  input  logic [255:0] i_core_a_pow_e,
  input  logic         i_core_finished
);

  localparam logic [2:0] c_QUERY_RX = 3'd0;
  localparam logic [2:0] c_READ     = 3'd1;
  localparam logic [2:0] c_START    = 3'd2;
  localparam logic [2:0] c_WAIT     = 3'd3;
  localparam logic [2:0] c_QUERY_TX = 3'd4;
  localparam logic [2:0] c_WRITE    = 3'd5;

  localparam logic [4:0] c_RX_ADDR     = 5'(RX_BASE);
  localparam logic [4:0] c_TX_ADDR     = 5'(TX_BASE);
  localparam logic [4:0] c_STATUS_ADDR = 5'(STATUS_BASE);

`ifdef RSA_WRAPPER_FULL_BLOCK_EN
  localparam logic [5:0] c_LAST_TX = 6'd31;
`else
  localparam logic [5:0] c_LAST_TX = 6'd30;
`endif

  logic [2:0]   r_state;
  logic [5:0]   r_cnt;
  logic         r_key_loaded;
  logic         r_wait_armed;
  logic [255:0] r_n;
  logic [255:0] r_e;
  logic [255:0] r_a;
  logic [255:0] r_result;
  logic         r_avm_read;
  logic         r_avm_write;
  logic [4:0]   r_avm_address;
  logic [31:0]  r_avm_writedata;
  logic         r_core_start;

  logic [7:0]   w_rx_byte;
  logic [7:0]   w_tx_byte;
  logic         w_unused;

  assign w_rx_byte = avm_readdata[7:0];
`ifdef RSA_WRAPPER_FULL_BLOCK_EN
  assign w_tx_byte = r_result[255:248];
`else
  assign w_tx_byte = r_result[247:240];
`endif
  assign w_unused  = ^{avm_readdata[31:8], r_result[255:248]};

  // Avalon strobes are registered and dropped after every completed transfer,
  // so address/data only change while no request is outstanding.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state         <= c_QUERY_RX;
      r_cnt           <= 6'd0;
      r_key_loaded    <= 1'b0;
      r_wait_armed    <= 1'b0;
      r_n             <= '0;
      r_e             <= '0;
      r_a             <= '0;
      r_result        <= '0;
      r_avm_read      <= 1'b0;
      r_avm_write     <= 1'b0;
      r_avm_address   <= c_STATUS_ADDR;
      r_avm_writedata <= '0;
      r_core_start    <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        c_QUERY_RX: begin
          if (!r_avm_read) begin
            r_avm_read    <= 1'b1;
            r_avm_address <= c_STATUS_ADDR;
          end else if (!avm_waitrequest) begin
            r_avm_read <= 1'b0;
            if (avm_readdata[RX_OK_BIT]) r_state <= c_READ;
          end
        end
        c_READ: begin
          if (!r_avm_read) begin
            r_avm_read    <= 1'b1;
            r_avm_address <= c_RX_ADDR;
          end else if (!avm_waitrequest) begin
            r_avm_read <= 1'b0;
            if (!r_key_loaded) begin
              // Key phase: counter runs 0..63, upper half routes to e.
              if (!r_cnt[5]) r_n <= {r_n[247:0], w_rx_byte};
              else           r_e <= {r_e[247:0], w_rx_byte};
              r_cnt <= r_cnt + 6'd1;
              if (r_cnt == 6'd63) r_key_loaded <= 1'b1;
              r_state <= c_QUERY_RX;
            end else begin
              r_a <= {r_a[247:0], w_rx_byte};
              if (r_cnt == 6'd31) begin
                r_cnt        <= 6'd0;
                r_core_start <= 1'b1;
                r_state      <= c_START;
              end else begin
                r_cnt   <= r_cnt + 6'd1;
                r_state <= c_QUERY_RX;
              end
            end
          end
        end
        c_START: begin
          r_wait_armed <= 1'b0;
          r_state      <= c_WAIT;
        end
        c_WAIT: begin
          // The core still reports idle during the first WAIT cycle.
          if (!r_wait_armed) begin
            r_wait_armed <= 1'b1;
          end else if (i_core_finished) begin
            r_result <= i_core_a_pow_e;
            r_state  <= c_QUERY_TX;
          end
        end
        c_QUERY_TX: begin
          if (!r_avm_read) begin
            r_avm_read    <= 1'b1;
            r_avm_address <= c_STATUS_ADDR;
          end else if (!avm_waitrequest) begin
            r_avm_read <= 1'b0;
            if (avm_readdata[TX_OK_BIT]) r_state <= c_WRITE;
          end
        end
        c_WRITE: begin
          if (!r_avm_write) begin
            r_avm_write     <= 1'b1;
            r_avm_address   <= c_TX_ADDR;
            r_avm_writedata <= {24'd0, w_tx_byte};
          end else if (!avm_waitrequest) begin
            r_avm_write <= 1'b0;
            r_result    <= r_result << 8;
            if (r_cnt == c_LAST_TX) begin
              r_cnt   <= 6'd0;
              r_state <= c_QUERY_RX;
            end else begin
              r_cnt   <= r_cnt + 6'd1;
              r_state <= c_QUERY_TX;
            end
          end
        end
        default: r_state <= c_QUERY_RX;
      endcase
    end
  end

  assign avm_address   = r_avm_address;
  assign avm_read      = r_avm_read;
  assign avm_write     = r_avm_write;
  assign avm_writedata = r_avm_writedata;
  assign o_core_start  = r_core_start;
  assign o_core_a      = r_a;
  assign o_core_e      = r_e;
  assign o_core_n      = r_n;

endmodule

`default_nettype wire
